// File: rtl/alu_result_display_if.sv
// Signal bundle between the ALU output stage and the seven-segment display driver.
// The master drives the capture/blank controls and the slave drives the display pins.
interface alu_result_display_if;
    logic [15:0] value;
    logic        cout_in;
    logic        zero_in;
    logic        load;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;

    modport master (
        output value, cout_in, zero_in, load, blank,
        input  an, seg, dp, digit_idx
    );

    modport slave (
        input  value, cout_in, zero_in, load, blank,
        output an, seg, dp, digit_idx
    );
endinterface

// File: rtl/alu_result_display.sv
// Holds the ALU result and flags, then scans them as four hex digits on a common-anode display.
// an/seg/dp lag the scan state by one cycle, digit_idx has no lag, and there is no backpressure.
module alu_result_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4,
    parameter int LZ_BLANK    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_result_display_if.slave  bus
);
    localparam int              CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   CNT_GUARD = CW'(GUARD);

    logic [CW-1:0] cnt;
    logic [1:0]    digit_idx;
    logic [15:0]   hv;
    logic          hc;
    logic          hz;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    logic [3:0]    nib;
    logic          lz_hide;
    logic [6:0]    seg_nxt;
    logic [3:0]    an_nxt;
    logic          dp_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        nib     = hv[{digit_idx, 2'b00} +: 4];
        // A digit is hidden when it and every digit to its left are zero.
        lz_hide = (LZ_BLANK != 0) && (digit_idx != 2'd0)
                  && ((hv >> {digit_idx, 2'b00}) == 16'd0);
        seg_nxt = lz_hide ? 7'h7F : hex7(nib);
        an_nxt  = (bus.blank || (cnt < CNT_GUARD)) ? 4'hF : ~(4'b0001 << digit_idx);
        dp_nxt  = !(((digit_idx == 2'd0) && hc) || ((digit_idx == 2'd3) && hz));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            digit_idx <= 2'd0;
            hv        <= 16'd0;
            hc        <= 1'b0;
            hz        <= 1'b0;
            an_q      <= 4'hF;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            if (bus.load) begin
                hv <= bus.value;
                hc <= bus.cout_in;
                hz <= bus.zero_in;
            end
            if (cnt == CNT_LAST) begin
                cnt       <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.digit_idx = digit_idx;
endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboarded bench for alu_result_display: a cycle-time reference model queues expected pins,
// a negedge monitor compares both a blanking and a non-blanking instance against them.
module tb_alu_result_display;
    localparam int RD = 8;
    localparam int GD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_result_display_if bus0 ();
    alu_result_display_if bus1 ();

    assign bus1.value   = bus0.value;
    assign bus1.cout_in = bus0.cout_in;
    assign bus1.zero_in = bus0.zero_in;
    assign bus1.load    = bus0.load;
    assign bus1.blank   = bus0.blank;

    alu_result_display #(.REFRESH_DIV(RD), .GUARD(GD), .LZ_BLANK(1)) dut_lz (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    alu_result_display #(.REFRESH_DIV(RD), .GUARD(GD), .LZ_BLANK(0)) dut_nz (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg_lz;
        logic [6:0] seg_nz;
        logic       dp;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: cycles elapsed since reset plus the held capture.
    int unsigned m_t  = 0;
    int unsigned m_hv = 0;
    bit          m_hc = 0;
    bit          m_hz = 0;

    function automatic logic [6:0] ref_seg(int unsigned hv, int k, bit lz);
        int unsigned d;
        d = (hv >> (4 * k)) & 15;
        if (lz && k > 0 && hv < (32'd1 << (4 * k)))
            return 7'h7F;
        return seg_tab[d];
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int   slot;
        int   phase;
        if (rst) begin
            e.an = 4'hF; e.seg_lz = 7'h7F; e.seg_nz = 7'h7F; e.dp = 1'b1; e.idx = 2'd0;
            m_t = 0; m_hv = 0; m_hc = 0; m_hz = 0;
        end else begin
            slot  = (m_t / RD) % 4;
            phase = m_t % RD;
            e.an     = (bus0.blank || phase < GD) ? 4'hF : ~(4'(1) << slot);
            e.seg_lz = ref_seg(m_hv, slot, 1'b1);
            e.seg_nz = ref_seg(m_hv, slot, 1'b0);
            e.dp     = ((slot == 0 && m_hc) || (slot == 3 && m_hz)) ? 1'b0 : 1'b1;
            e.idx    = 2'(((m_t + 1) / RD) % 4);
            if (bus0.load) begin
                m_hv = bus0.value; m_hc = bus0.cout_in; m_hz = bus0.zero_in;
            end
            m_t = m_t + 1;
        end
        exp_q.push_back(e);
    end

    task automatic chk(string nm, logic [15:0] act, logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("an_lz",  16'(bus0.an),        16'(e.an));
            chk("seg_lz", 16'(bus0.seg),       16'(e.seg_lz));
            chk("dp_lz",  16'(bus0.dp),        16'(e.dp));
            chk("idx_lz", 16'(bus0.digit_idx), 16'(e.idx));
            chk("an_nz",  16'(bus1.an),        16'(e.an));
            chk("seg_nz", 16'(bus1.seg),       16'(e.seg_nz));
            chk("dp_nz",  16'(bus1.dp),        16'(e.dp));
            chk("idx_nz", 16'(bus1.digit_idx), 16'(e.idx));
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(logic [15:0] v, logic c, logic z);
        bus0.value = v; bus0.cout_in = c; bus0.zero_in = z; bus0.load = 1'b1;
        step(1);
        bus0.load = 1'b0;
    endtask

    // Advance until the next edge sees the given slot and prescaler phase.
    task automatic seek(int slot, int phase);
        for (int i = 0; i < 4 * RD && !(((m_t / RD) % 4) == slot && (m_t % RD) == phase); i++)
            step(1);
    endtask

    initial begin
        bus0.value = 16'd0; bus0.cout_in = 1'b0; bus0.zero_in = 1'b0;
        bus0.load  = 1'b0;  bus0.blank   = 1'b0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(4 * RD);

        do_load(16'h1A3F, 1'b0, 1'b0);
        step(5 * RD);
        bus0.value = 16'hBEEF;
        step(4 * RD);

        do_load(16'h0005, 1'b0, 1'b0);
        step(5 * RD);
        do_load(16'h0000, 1'b0, 1'b1);
        step(5 * RD);
        do_load(16'hFFFF, 1'b1, 1'b0);
        step(5 * RD);

        seek(0, RD - 1);
        do_load(16'h2222, 1'b0, 1'b0);
        step(4 * RD);

        bus0.blank = 1'b1;
        step(20);
        bus0.blank = 1'b0;
        step(4 * RD);

        for (int i = 0; i < 40; i++) begin
            bus0.value   = 16'($urandom);
            bus0.cout_in = 1'($urandom);
            bus0.zero_in = 1'($urandom);
            if ($urandom_range(3) == 0)
                bus0.value = bus0.value >> (4 * $urandom_range(3, 1));
            bus0.load  = ($urandom_range(2) == 0);
            bus0.blank = ($urandom_range(7) == 0);
            step(1);
            bus0.load = 1'b0;
            step($urandom_range(12, 1));
        end
        bus0.blank = 1'b0;

        do_load(16'h8421, 1'b1, 1'b1);
        step(RD);
        seek(2, 4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(5 * RD);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
